// File: rtl/demux_stream_n.sv
// Registered 1-to-NUM_CH stream demultiplexer. Routing is either by explicit
// select or round-robin, and a frame_done pulse follows the last round-robin lane.
module demux_stream_n #(
  parameter int W      = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [W-1:0]        in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_CH*W-1:0] out_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic [SEL_W-1:0]    rr_ptr,
  output logic                frame_done
);

  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0][W-1:0] data_q;
  logic [NUM_CH-1:0]        valid_q;
  logic [SEL_W-1:0]         ptr_q;
  logic                     done_q;
  logic [SEL_W-1:0]         tgt;
  logic                     accept;

  // Out-of-range explicit selects fold onto the last lane.
  always_comb begin
    tgt = ptr_q;
    if (!mode) begin
      tgt = ({1'b0, sel} >= NUM_CH_X) ? LAST_CH : sel;
    end
  end

  // Handshake: a word moves on a port when valid && ready at the rising edge.
  // in_ready depends only on the target lane state and clr, never on in_valid,
  // so a lane draining in the same cycle can immediately take the next word.
  assign in_ready = !clr && (!valid_q[tgt] || out_ready[tgt]);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr) begin
          data_q[c]  <= '0;
          valid_q[c] <= 1'b0;
        end else if (accept && (tgt == SEL_W'(c))) begin
          data_q[c]  <= in_data;
          valid_q[c] <= 1'b1;
        end else if (valid_q[c] && out_ready[c]) begin
          valid_q[c] <= 1'b0;
        end
      end
    end
  end

  // The pointer only moves on round-robin accepts, so a mode=0 detour
  // leaves a partially filled frame to be resumed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      done_q <= 1'b0;
    end else if (clr) begin
      ptr_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= accept && mode && (ptr_q == LAST_CH);
      if (accept && mode) begin
        ptr_q <= (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign rr_ptr     = ptr_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_demux_stream_n.sv
// Directed bench for demux_stream_n: a 4-lane instance for most scenarios and
// a 3-lane instance for the select clamp on a non power-of-two lane count.
module tb_demux_stream_n;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic        frame_done;

  logic        in_valid3;
  logic        in_ready3;
  logic [47:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [1:0]  rr_ptr3;
  logic        frame_done3;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  demux_stream_n #(.W(W), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .rr_ptr(rr_ptr), .frame_done(frame_done)
  );

  demux_stream_n #(.W(W), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .rr_ptr(rr_ptr3), .frame_done(frame_done3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    in_valid = 1'b0; in_valid3 = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; mode = 1'b0; sel = 2'd0; in_data = '0;
    in_valid = 1'b0; in_valid3 = 1'b0; out_ready = '0; out_ready3 = '0;
    #1;
    n_checks++;
    if (out_valid !== 4'b0000 || out_data !== 64'h0 || rr_ptr !== 2'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h ptr=%0d done=%b, required all zero",
               out_valid, out_data, rr_ptr, frame_done);
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_explicit();
    mode = 1'b0; sel = 2'd2; in_data = 16'h1234; in_valid = 1'b1; out_ready = 4'b0000;
    step();
    n_checks++;
    if (out_valid !== 4'b0100 || out_data !== 64'h0000_1234_0000_0000) begin
      n_fail++;
      $display("FAIL explicit_load: valid=%b data=%h, required 0100 / 0000123400000000", out_valid, out_data);
    end
    in_data = 16'h9999;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL explicit_stall_ready: got %b, required 0", in_ready);
    end
    step();
    n_checks++;
    if (out_data[2*W +: W] !== 16'h1234 || out_valid !== 4'b0100) begin
      n_fail++;
      $display("FAIL explicit_no_overwrite: ch2=%h valid=%b, required 1234 / 0100", out_data[2*W +: W], out_valid);
    end
    out_ready = 4'b0100; in_data = 16'h5678;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL explicit_drain_ready: got %b, required 1", in_ready);
    end
    step();
    n_checks++;
    if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 16'h5678) begin
      n_fail++;
      $display("FAIL explicit_drain_load: valid=%b ch2=%h, required 0100 / 5678", out_valid, out_data[2*W +: W]);
    end
    // Park a word on lane 0, then drain lane 2 alone.
    in_valid = 1'b1; sel = 2'd0; in_data = 16'hBEEF; out_ready = 4'b0000;
    step();
    in_valid = 1'b0; out_ready = 4'b0100;
    step();
    n_checks++;
    if (out_valid !== 4'b0001 || out_data !== 64'h0000_5678_0000_BEEF) begin
      n_fail++;
      $display("FAIL explicit_independent: valid=%b data=%h, required 0001 / 000056780000BEEF", out_valid, out_data);
    end
    out_ready = 4'b0000;
  endtask

  task automatic test_sel_clamp();
    clear_all();
    mode = 1'b0; sel = 2'd3; in_data = 16'h00AA; in_valid3 = 1'b1; out_ready3 = 3'b000;
    step();
    in_valid3 = 1'b0;
    n_checks++;
    if (out_valid3 !== 3'b100 || out_data3 !== 48'h00AA_0000_0000) begin
      n_fail++;
      $display("FAIL sel_clamp: valid=%b data=%h, required 100 / 00AA00000000", out_valid3, out_data3);
    end
  endtask

  task automatic test_round_robin();
    clear_all();
    mode = 1'b1; out_ready = 4'b1111;
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'(i); in_valid = 1'b1;
      exp_q.push_back(16'(i));
      #1;
      n_checks++;
      if (rr_ptr !== 2'((i - 1) % 4) || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_ptr_seq[%0d]: ptr=%0d ready=%b, required %0d / 1", i, rr_ptr, in_ready, (i - 1) % 4);
      end
      step();
      begin
        int ch = (i - 1) % 4;
        logic [W-1:0] exp = exp_q.pop_front();
        n_checks++;
        if (out_valid[ch] !== 1'b1 || out_data[ch*W +: W] !== exp) begin
          n_fail++;
          $display("FAIL rr_data[%0d]: ch%0d valid=%b data=%h, required 1 / %h", i, ch, out_valid[ch], out_data[ch*W +: W], exp);
        end
        n_checks++;
        if (frame_done !== (i % 4 == 0)) begin
          n_fail++;
          $display("FAIL rr_frame_done[%0d]: got %b, required %b", i, frame_done, (i % 4 == 0));
        end
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (frame_done !== 1'b0 || rr_ptr !== 2'd0) begin
      n_fail++;
      $display("FAIL rr_done_single: done=%b ptr=%0d, required 0 / 0", frame_done, rr_ptr);
    end
  endtask

  task automatic test_mode_switch();
    clear_all();
    mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
    in_data = 16'h0010; step();
    in_data = 16'h0020; step();
    mode = 1'b0; sel = 2'd0; in_data = 16'h0030;
    step();
    n_checks++;
    if (rr_ptr !== 2'd2 || out_data[0 +: W] !== 16'h0030 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL switch_hold: ptr=%0d ch0=%h done=%b, required 2 / 0030 / 0", rr_ptr, out_data[0 +: W], frame_done);
    end
    mode = 1'b1; in_data = 16'h0040;
    step();
    n_checks++;
    if (out_valid[2] !== 1'b1 || out_data[2*W +: W] !== 16'h0040 || rr_ptr !== 2'd3) begin
      n_fail++;
      $display("FAIL switch_resume: v2=%b ch2=%h ptr=%0d, required 1 / 0040 / 3", out_valid[2], out_data[2*W +: W], rr_ptr);
    end
    in_data = 16'h0050;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_data[3*W +: W] !== 16'h0050 || frame_done !== 1'b1 || rr_ptr !== 2'd0) begin
      n_fail++;
      $display("FAIL switch_frame: ch3=%h done=%b ptr=%0d, required 0050 / 1 / 0", out_data[3*W +: W], frame_done, rr_ptr);
    end
  endtask

  task automatic test_clr();
    clear_all();
    mode = 1'b1; out_ready = 4'b0000; in_valid = 1'b1;
    in_data = 16'h0A0A; step();
    in_data = 16'h0B0B; step();
    clr = 1'b1; in_data = 16'h0C0C;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ready: got %b, required 0", in_ready);
    end
    step();
    clr = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b0000 || out_data !== 64'h0 || rr_ptr !== 2'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_state: valid=%b data=%h ptr=%0d done=%b, required all zero", out_valid, out_data, rr_ptr, frame_done);
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; out_ready = 4'b0000; in_valid = 1'b1;
    in_data = 16'h1111; step();
    in_data = 16'h2222; step();
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 4'b0000 || out_data !== 64'h0 || rr_ptr !== 2'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b data=%h ptr=%0d, required all zero before any edge", out_valid, out_data, rr_ptr);
    end
    step(); step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discard: valid=%b ready=%b, required 0000 / 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_explicit();
    test_sel_clamp();
    test_round_robin();
    test_mode_switch();
    test_clr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
